// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder.
// The testbench drives the master side and the adder uses the slave side.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, sub,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one result bit per clock, LSB first, WIDTH cycles per op.
// Define SERIAL_ADDER_CTRL_SUB_EN to enable a-b via the captured sub bit.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic             ai, bi, p, g1, g2;
  logic             sum, c_nxt;
  logic [WIDTH-1:0] r_nxt;

  always_comb begin
    ai = a_sh_q[0];
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    bi = b_sh_q[0] ^ sub_q;
`else
    bi = b_sh_q[0];
`endif
    p     = ai ^ bi;
    g1    = ai & bi;
    sum   = p ^ c_q;
    g2    = p & c_q;
    c_nxt = g1 | g2;
    r_nxt = (r_q >> 1) | (WIDTH'(sum) << (WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          r_d     = '0;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
          sub_d   = bus.sub;
          c_d     = bus.sub;
`else
          c_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_d    = r_nxt;
        c_d    = c_nxt;
        cnt_d  = cnt_q + 1'b1;
        // c_q here is the carry into the MSB
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          s_d     = r_nxt;
          co_d    = c_nxt;
          ovf_d   = c_q ^ c_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8.
// Build with SERIAL_ADDER_CTRL_SUB_EN to match a subtract-enabled DUT.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [W-1:0] model_s = '0;
  logic [W-1:0] run_hold = '0;
  logic prev_done = 1'b0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sub);
    exp_t e;
    logic [W-1:0] bb;
    logic         cin;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb  = b;
    cin = 1'b0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    if (sub) begin
      bb  = ~b;
      cin = 1'b1;
    end
`else
    if (sub) bb = b;
`endif
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    low   = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cin};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.ovf = low[W-1] ^ full[W];
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      chk("done_pulse", {31'b0, prev_done}, 0);
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("s", {24'b0, bus.s}, {24'b0, e.s});
        chk("co", {31'b0, bus.co}, {31'b0, e.co});
        chk("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
        chk("latency", cyc - e.cyc, W);
      end
    end
    prev_done = bus.done;
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    @(posedge clk);
    #1;
    e        = model(a, b, sub);
    e.cyc    = cyc;
    run_hold = model_s;
    model_s  = e.s;
    sb.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic watch_run(bit inject);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", {31'b0, bus.busy}, 1);
      chk("s_hold", {24'b0, bus.s}, {24'b0, run_hold});
      if (inject && i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.sub   = 1'b1;
      end else if (inject && i == 3) begin
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_s", {24'b0, bus.s}, 0);
    chk("rst_co", {31'b0, bus.co}, 0);
    chk("rst_ovf", {31'b0, bus.ovf}, 0);
    rst_n = 1'b1;

    issue(8'h0F, 8'h01, 1'b0);
    watch_run(1'b0);
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'b0, bus.busy}, 0);
    chk("idle_done", {31'b0, bus.done}, 0);

    issue(8'hFF, 8'h01, 1'b0);
    watch_run(1'b0);
    issue(8'h7F, 8'h01, 1'b0);
    watch_run(1'b0);

    issue(8'h0F, 8'h01, 1'b0);
    watch_run(1'b1);
    repeat (3) @(negedge clk);

    issue(8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_done", {31'b0, bus.done}, 0);
    chk("abort_s", {24'b0, bus.s}, 0);
    chk("abort_co", {31'b0, bus.co}, 0);
    chk("abort_ovf", {31'b0, bus.ovf}, 0);
    rst_n = 1'b1;
    void'(sb.pop_back());
    model_s = '0;
    repeat (12) @(negedge clk);

    issue(8'h03, 8'h04, 1'b0);
    watch_run(1'b0);
    issue(8'h05, 8'h07, 1'b1);
    watch_run(1'b0);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      watch_run(1'b0);
      if (k[0]) repeat (2) @(negedge clk);
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
